// File: rtl/sha256_w_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63], one word per cycle.
// Define SHA256_W_STALL_EN to add a stall input that freezes the schedule while in RUN.
module sha256_w_schedule (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
`ifdef SHA256_W_STALL_EN
    input  logic         stall,
`endif
    input  logic [511:0] M,
    output logic [5:0]   round,
    output logic [31:0]  Wt,
    output logic         Wt_valid,
    output logic         last,
    output logic         busy
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [5:0]        n_q, n_d;
    logic [15:0][31:0] w_q, w_d;
    logic [31:0]       wt_q, wt_d;
    logic              wt_valid_q, wt_valid_d;
    logic              last_q, last_d;
    logic              advance;
    logic [31:0]       w_next;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

`ifdef SHA256_W_STALL_EN
    assign advance = ~stall;
`else
    assign advance = 1'b1;
`endif

    // w_q[0] always holds W[n]; the new tail word is W[n+16].
    assign w_next = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        w_d        = w_q;
        wt_d       = wt_q;
        wt_valid_d = 1'b0;
        last_d     = 1'b0;
        if (state_q == StIdle) begin
            if (start) begin
                state_d = StRun;
                n_d     = 6'd0;
                for (int i = 0; i < 16; i++) begin
                    w_d[i] = M[32*(15-i) +: 32];
                end
            end
        end else if (advance) begin
            wt_d       = w_q[0];
            wt_valid_d = 1'b1;
            last_d     = (n_q == 6'd63);
            for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i+1];
            end
            w_d[15] = w_next;
            if (n_q == 6'd63) begin
                state_d = StIdle;
                n_d     = 6'd0;
            end else begin
                n_d = n_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            n_q        <= 6'd0;
            w_q        <= '0;
            wt_q       <= 32'd0;
            wt_valid_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            w_q        <= w_d;
            wt_q       <= wt_d;
            wt_valid_q <= wt_valid_d;
            last_q     <= last_d;
        end
    end

    // The external K ROM registers K[round] on the same edge Wt registers W[n].
    assign round    = (state_q == StRun) ? n_q : 6'd0;
    assign busy     = (state_q == StRun);
    assign Wt       = wt_q;
    assign Wt_valid = wt_valid_q;
    assign last     = last_q;

endmodule

// File: tb/tb_sha256_w_schedule.sv
// Bench for sha256_w_schedule: scoreboard of model words, registered K ROM on round.
// Define SHA256_W_STALL_EN to also exercise the stall input.
module tb_sha256_w_schedule;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [31:0] w;
        logic        lst;
        int          idx;
        logic        kat_en;
        logic [31:0] kat;
    } sb_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [511:0] M = '0;
    logic [5:0]   round;
    logic [31:0]  Wt;
    logic         Wt_valid;
    logic         last;
    logic         busy;
`ifdef SHA256_W_STALL_EN
    logic         stall = 1'b0;
    logic         stall_rand = 1'b0;
`endif

    logic [31:0]  kt = 32'd0;
    logic         rst_q = 1'b1;
    logic [31:0]  held_wt = 32'd0;
    logic         word_now = 1'b0;
    logic         last_now = 1'b0;
    int           seen_idx = -1;
    int           words_seen = 0;
    int           checks = 0;
    int           errors = 0;
    sb_t          sb [$];
    sb_t          e;
    logic [31:0]  wm [64];
    logic [511:0] m_abc, m2, m3, m_bad;

    sha256_w_schedule dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef SHA256_W_STALL_EN
        .stall    (stall),
`endif
        .M        (M),
        .round    (round),
        .Wt       (Wt),
        .Wt_valid (Wt_valid),
        .last     (last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Registered K ROM addressed by round, as the surrounding core would have it.
    always @(posedge clk) begin
        kt    <= K_TAB[round];
        rst_q <= reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic push_block(input logic [511:0] m, input logic is_abc);
        sb_t ent;
        for (int t = 0; t < 16; t++) wm[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) wm[t] = s1(wm[t-2]) + wm[t-7] + s0(wm[t-15]) + wm[t-16];
        for (int t = 0; t < 64; t++) begin
            ent.w      = wm[t];
            ent.lst    = (t == 63);
            ent.idx    = t;
            ent.kat_en = is_abc && (t == 0 || t == 15 || t == 16 || t == 17);
            ent.kat    = (t == 15) ? 32'h00000018 : (t == 17) ? 32'h000f0000 : 32'h61626380;
            sb.push_back(ent);
        end
        words_seen = 0;
    endtask

    always @(negedge clk) begin
        word_now = 1'b0;
        last_now = 1'b0;
        if (rst_q) begin
            chk("rst_valid", 32'(Wt_valid), 32'd0);
            chk("rst_last", 32'(last), 32'd0);
            chk("rst_wt", Wt, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_round", 32'(round), 32'd0);
            held_wt = 32'd0;
        end else if (Wt_valid) begin
            chk("word_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("w%0d", e.idx), Wt, e.w);
                chk($sformatf("last%0d", e.idx), 32'(last), 32'(e.lst));
                chk($sformatf("kt%0d", e.idx), kt, K_TAB[e.idx]);
                if (e.kat_en) chk($sformatf("kat%0d", e.idx), Wt, e.kat);
                if (last) chk("busy_at_last", 32'(busy), 32'd0);
                seen_idx = e.idx;
                words_seen++;
            end
            word_now = 1'b1;
            last_now = last;
            held_wt  = Wt;
        end else begin
            chk("idle_last", 32'(last), 32'd0);
            chk("hold_wt", Wt, held_wt);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
`ifdef SHA256_W_STALL_EN
        if (stall_rand) stall = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic wait_last(input int budget);
        int c = 0;
        while (!last_now && c < budget) begin
            step();
            c++;
        end
        chk("last_seen", 32'(last_now), 32'd1);
        chk("word_count", 32'(words_seen), 32'd64);
    endtask

    task automatic wait_word(input int idx, input int budget);
        int c = 0;
        while (!(word_now && seen_idx == idx) && c < budget) begin
            step();
            c++;
        end
        chk("word_reached", 32'(word_now && seen_idx == idx), 32'd1);
    endtask

    initial begin
        m_abc = {32'h61626380, 448'd0, 32'h00000018};
        for (int i = 0; i < 16; i++) begin
            m2[32*i +: 32]    = 32'h9e3779b9 * (i + 1);
            m3[32*i +: 32]    = 32'h01234567 ^ (32'h0f1e2d3c << i);
            m_bad[32*i +: 32] = 32'hdeadbeef + i;
        end

        repeat (2) step();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_round", 32'(round), 32'd0);
            chk("idle_valid", 32'(Wt_valid), 32'd0);
            chk("idle_wt", Wt, 32'd0);
        end

        // abc block; a second start mid-block must be ignored.
        M = m_abc;
        start = 1'b1;
        push_block(m_abc, 1'b1);
        step();
        start = 1'b0;
        M = '0;
        chk("busy_run", 32'(busy), 32'd1);
        chk("first_gap", 32'(Wt_valid), 32'd0);
        repeat (3) step();
        M = m_bad;
        start = 1'b1;
        repeat (2) step();
        start = 1'b0;
        M = '0;
        wait_last(200);

        // Back-to-back: start in the cycle last is high.
        M = m2;
        start = 1'b1;
        push_block(m2, 1'b0);
        step();
        start = 1'b0;
        M = '0;
        chk("b2b_gap", 32'(Wt_valid), 32'd0);
        step();
        chk("b2b_valid", 32'(Wt_valid), 32'd1);
        chk("b2b_w0", Wt, m2[511:480]);
        wait_last(200);
        repeat (3) step();
        chk("done_busy", 32'(busy), 32'd0);

        // Abort at word 30, then a clean restart.
        M = m3;
        start = 1'b1;
        push_block(m3, 1'b0);
        step();
        start = 1'b0;
        wait_word(30, 200);
        reset = 1'b1;
        step();
        sb.delete();
        reset = 1'b0;
        repeat (4) step();
        chk("abort_busy", 32'(busy), 32'd0);
        M = m3;
        start = 1'b1;
        push_block(m3, 1'b0);
        step();
        start = 1'b0;
        wait_last(200);
        repeat (2) step();

`ifdef SHA256_W_STALL_EN
        stall = 1'b1;
        repeat (4) step();
        chk("stall_idle_busy", 32'(busy), 32'd0);
        M = m_abc;
        start = 1'b1;
        push_block(m_abc, 1'b1);
        step();
        start = 1'b0;
        chk("stall_idle_start", 32'(busy), 32'd1);
        stall_rand = 1'b1;
        wait_last(600);
        stall_rand = 1'b0;
        stall = 1'b0;
        repeat (2) step();
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
